// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer: sweeps every input vector of an N_IN-input gate, samples its output
// and scores it against an expected truth table. Optional GATE_SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    localparam int T     = 1 << N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [T-1:0]    expected,
    output logic [N_IN-1:0] gate_in,
    input  logic            gate_out,
    output logic            busy,
    output logic            done,
    output logic [T-1:0]    truth,
    output logic [N_IN:0]   fail_count,
    output logic            pass
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [T-1:0]      exp_q, exp_d;
    logic [N_IN-1:0]   gate_in_q, gate_in_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [T-1:0]      truth_q, truth_d;
    logic [N_IN:0]     fail_count_q, fail_count_d;
    logic              pass_q, pass_d;
    logic              mism, last;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        exp_d        = exp_q;
        gate_in_d    = gate_in_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        truth_d      = truth_q;
        fail_count_d = fail_count_q;
        pass_d       = pass_q;
        mism         = 1'b0;
        last         = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    exp_d        = expected;
                    truth_d      = '0;
                    fail_count_d = '0;
                    pass_d       = 1'b0;
                    idx_d        = '0;
                    cnt_d        = '0;
                    gate_in_d    = '0;
                    busy_d       = 1'b1;
                    state_d      = DRIVE;
                end
            end
            DRIVE: begin
                gate_in_d = idx_q;
                busy_d    = 1'b1;
                if (cnt_q == CW'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SAMPLE: begin
                truth_d[idx_q] = gate_out;
                mism = (gate_out != exp_q[idx_q]);
                if (mism) fail_count_d = fail_count_q + (N_IN+1)'(1);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                last = mism || (idx_q == N_IN'(T - 1));
`else
                last = (idx_q == N_IN'(T - 1));
`endif
                if (last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d     = idx_q + N_IN'(1);
                    gate_in_d = idx_q + N_IN'(1);
                    state_d   = DRIVE;
                end
            end
            DONE: begin
                // gate_in still shows the last vector during DONE; it parks at 0 on return to IDLE
                pass_d    = (fail_count_q == '0);
                gate_in_d = '0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            exp_q        <= '0;
            gate_in_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            truth_q      <= '0;
            fail_count_q <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            exp_q        <= exp_d;
            gate_in_q    <= gate_in_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            truth_q      <= truth_d;
            fail_count_q <= fail_count_d;
            pass_q       <= pass_d;
        end
    end

    assign gate_in    = gate_in_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign truth      = truth_q;
    assign fail_count = fail_count_q;
    assign pass       = pass_q;
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3) driving table-defined gate models,
// checked against a truth-table level reference model. Honours GATE_SWEEP_STOP_ON_FAIL_EN.
module tb_gate_sweep_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] expv = '0;
    logic [3:0] gtab = '0;
    int         sel = 1;
    int         n_asserts = 0;
    int         n_fail = 0;

    logic [1:0] gi1, gi3;
    logic       go1, go3, busy1, busy3, done1, done3, pass1, pass3, start1, start3;
    logic [3:0] truth1, truth3;
    logic [2:0] fc1, fc3;

    always #5 clk = ~clk;

    assign start1 = start && (sel == 1);
    assign start3 = start && (sel == 3);
    assign go1    = gtab[gi1];
    assign go3    = gtab[gi3];

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .expected(expv), .gate_in(gi1), .gate_out(go1),
        .busy(busy1), .done(done1), .truth(truth1), .fail_count(fc1), .pass(pass1));

    gate_sweep_ctrl #(.N_IN(2), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .expected(expv), .gate_in(gi3), .gate_out(go3),
        .busy(busy3), .done(done3), .truth(truth3), .fail_count(fc3), .pass(pass3));

    logic [1:0] o_gi;
    logic       o_busy, o_done, o_pass;
    logic [3:0] o_truth;
    logic [2:0] o_fc;
    assign o_gi    = (sel == 1) ? gi1    : gi3;
    assign o_busy  = (sel == 1) ? busy1  : busy3;
    assign o_done  = (sel == 1) ? done1  : done3;
    assign o_pass  = (sel == 1) ? pass1  : pass3;
    assign o_truth = (sel == 1) ? truth1 : truth3;
    assign o_fc    = (sel == 1) ? fc1    : fc3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, ".gate_in"}, 32'(o_gi), 32'd0);
        chk({tag, ".busy"}, 32'(o_busy), 32'd0);
        chk({tag, ".done"}, 32'(o_done), 32'd0);
        chk({tag, ".truth"}, 32'(o_truth), 32'd0);
        chk({tag, ".fail_count"}, 32'(o_fc), 32'd0);
        chk({tag, ".pass"}, 32'(o_pass), 32'd0);
    endtask

    // One sweep on instance s with gate table g and expected table e; start seen at edge 0.
    task automatic sweep(input string tag, input int s, input logic [3:0] g, input logic [3:0] e,
                         input bit repulse);
        int nvec, efc, d, m;
        logic [3:0] et;
        nvec = 4; efc = 0; et = '0;
        for (int i = 0; i < 4; i++) if (g[i] != e[i]) efc++;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        m = 4;
        for (int i = 3; i >= 0; i--) if (g[i] != e[i]) m = i;
        if (m < 4) begin nvec = m + 1; efc = 1; end
`else
        m = 4;
`endif
        for (int i = 0; i < nvec; i++) et[i] = g[i];
        d = 1 + nvec * (s + 1);
        sel = s; gtab = g; expv = e;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= d + 1; c++) begin
            @(negedge clk);
            start = repulse && (c == 3 || c == 6);
            if (repulse && c == 4) expv = 4'b0000;
            if (c < d) begin
                chk({tag, ".gate_in"}, 32'(o_gi), 32'((c - 1) / (s + 1)));
                chk({tag, ".busy"}, 32'(o_busy), 32'd1);
                chk({tag, ".done_early"}, 32'(o_done), 32'd0);
            end else if (c == d) begin
                chk({tag, ".done"}, 32'(o_done), 32'd1);
                chk({tag, ".busy_done"}, 32'(o_busy), 32'd1);
                chk({tag, ".truth"}, 32'(o_truth), 32'(et));
                chk({tag, ".fail_count"}, 32'(o_fc), 32'(efc));
            end else begin
                chk({tag, ".done_after"}, 32'(o_done), 32'd0);
                chk({tag, ".busy_after"}, 32'(o_busy), 32'd0);
                chk({tag, ".gate_in_after"}, 32'(o_gi), 32'd0);
                chk({tag, ".pass"}, 32'(o_pass), 32'(efc == 0));
                chk({tag, ".truth_held"}, 32'(o_truth), 32'(et));
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] g, e;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        sel = 1; chk_idle_reset("reset1");
        sel = 3; chk_idle_reset("reset3");
        rst = 1'b0;
        @(negedge clk);

        sweep("and",      1, 4'b1000, 4'b1000, 1'b0);
        sweep("xor",      1, 4'b0110, 4'b1000, 1'b0);
        sweep("and_s3",   3, 4'b1000, 4'b1000, 1'b0);
        sweep("repulse",  1, 4'b1000, 4'b1000, 1'b1);

        // mid-sweep reset: start at edge 0, rst sampled at edge 5
        sel = 1; gtab = 4'b1001; expv = 4'b1000;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 5) rst = 1'b1;
            if (c == 6) chk_idle_reset("midrst");
        end
        rst = 1'b0;
        @(negedge clk);
        sweep("after_rst", 1, 4'b1000, 4'b1000, 1'b0);

        // rst and start together: rst wins
        sel = 1; rst = 1'b1; start = 1'b1;
        @(negedge clk);
        chk_idle_reset("rst_start");
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk({"rst_start", ".busy_later"}, 32'(o_busy), 32'd0);

        for (int k = 0; k < 8; k++) begin
            g = 4'($urandom_range(0, 15));
            e = (k % 3 == 0) ? g : 4'($urandom_range(0, 15));
            sweep($sformatf("rand%0d", k), (k % 2 == 0) ? 1 : 3, g, e, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
